// File: rtl/lsu_bus_sequencer.sv
// Memory-stage load/store sequencer: runs one RV32I load/store as one or two aligned word bus transactions.
// Latency: request accepted in IDLE, one FIRST (+ one SECOND if misaligned) state held until BusAck, then one DONE cycle.
// Backpressure: StallM holds the upstream pipeline until the final ack; bus outputs stay stable until BusAck.
module lsu_bus_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            StrobeM,
  input  logic [ADDR_WIDTH-1:0] AddrM,
  input  logic [31:0]           WriteDataM,
  output logic                  StallM,
  output logic [31:0]           ReadDataM,
  output logic                  BusReq,
  output logic                  BusWe,
  output logic [ADDR_WIDTH-1:0] BusAddr,
  output logic [31:0]           BusWData,
  output logic [3:0]            BusBE,
  input  logic [31:0]           BusRData,
  input  logic                  BusAck
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Registered bus side and load assembly state
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [31:0]           r_bus_wdata;
  logic [3:0]            r_bus_be;
  logic [31:0]           r_lo;
  logic [31:0]           r_rdata;

  // Next values for the bus registers and capture strobes
  logic                  w_req_nxt;
  logic                  w_we_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [31:0]           w_wdata_nxt;
  logic [3:0]            w_be_nxt;
  logic                  w_ld_lo;
  logic                  w_ld_rdata;
  logic                  w_stall;

  // Lane arithmetic derived from the (stall-held) request inputs
  logic                  w_access;
  logic [1:0]            w_off;
  logic [4:0]            w_shamt;
  logic [3:0]            w_mask_n;
  logic [7:0]            w_mask8;
  logic                  w_split;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [63:0]           w_wdata64;
  logic [31:0]           w_lo;
  logic [31:0]           w_hi;
  logic [31:0]           w_raw;
  logic [31:0]           w_ext;

  assign w_access    = MemReadM | MemWriteM;
  assign w_off       = AddrM[1:0];
  assign w_shamt     = {w_off, 3'b000};
  assign w_word_addr = {AddrM[ADDR_WIDTH-1:2], 2'b00};
  assign w_wdata64   = {32'b0, WriteDataM} << w_shamt;
  assign w_mask8     = {4'b0000, w_mask_n} << w_off;
  // Any enabled byte beyond lane 3 means the access crosses into the next word
  assign w_split     = |w_mask8[7:4];

  // Byte mask for the access size; size 11 behaves as a word
  always_comb begin
    case (StrobeM[1:0])
      2'b00:   w_mask_n = 4'b0001;
      2'b01:   w_mask_n = 4'b0011;
      default: w_mask_n = 4'b1111;
    endcase
  end

  // The final ack of a split load supplies the upper word; a single ack supplies the lower word
  assign w_lo  = (r_state == S_SECOND) ? r_lo     : BusRData;
  assign w_hi  = (r_state == S_SECOND) ? BusRData : 32'b0;
  assign w_raw = 32'({w_hi, w_lo} >> w_shamt);

  // Keep the low n bytes and sign- or zero-extend from the top kept byte
  always_comb begin
    case (StrobeM[1:0])
      2'b00:   w_ext = {{24{w_raw[7]  & ~StrobeM[2]}}, w_raw[7:0]};
      2'b01:   w_ext = {{16{w_raw[15] & ~StrobeM[2]}}, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; acks outside FIRST/SECOND are ignored
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_access) w_state_nxt = S_FIRST;
      S_FIRST:  if (BusAck)   w_state_nxt = w_split ? S_SECOND : S_DONE;
      S_SECOND: if (BusAck)   w_state_nxt = S_DONE;
      S_DONE:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: stall, next bus register values, load capture strobes
  always_comb begin
    w_req_nxt   = r_bus_req;
    w_we_nxt    = r_bus_we;
    w_addr_nxt  = r_bus_addr;
    w_wdata_nxt = r_bus_wdata;
    w_be_nxt    = r_bus_be;
    w_ld_lo     = 1'b0;
    w_ld_rdata  = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_access;
        if (w_access) begin
          w_req_nxt   = 1'b1;
          w_we_nxt    = MemWriteM;
          w_addr_nxt  = w_word_addr;
          w_wdata_nxt = w_wdata64[31:0];
          w_be_nxt    = w_mask8[3:0];
        end
      end
      S_FIRST: begin
        w_stall = 1'b1;
        if (BusAck) begin
          w_ld_lo = ~r_bus_we;
          if (w_split) begin
            w_addr_nxt  = w_word_addr + ADDR_WIDTH'(4);
            w_wdata_nxt = w_wdata64[63:32];
            w_be_nxt    = w_mask8[7:4];
          end else begin
            w_ld_rdata  = ~r_bus_we;
            w_req_nxt   = 1'b0;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = '0;
            w_wdata_nxt = '0;
            w_be_nxt    = '0;
          end
        end
      end
      S_SECOND: begin
        w_stall = 1'b1;
        if (BusAck) begin
          w_ld_rdata  = ~r_bus_we;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = '0;
          w_wdata_nxt = '0;
          w_be_nxt    = '0;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
        w_be_nxt    = '0;
      end
    endcase
  end

  // Bus registers, lower-word capture and the load result register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_lo        <= '0;
      r_rdata     <= '0;
    end else begin
      r_bus_req   <= w_req_nxt;
      r_bus_we    <= w_we_nxt;
      r_bus_addr  <= w_addr_nxt;
      r_bus_wdata <= w_wdata_nxt;
      r_bus_be    <= w_be_nxt;
      if (w_ld_lo) begin
        r_lo <= BusRData;
      end
      if (w_ld_rdata) begin
        r_rdata <= w_ext;
      end
    end
  end

  // Stall is masked while reset is held so the pipeline never sees a stale request
  assign StallM    = w_stall & ~RST;
  assign ReadDataM = r_rdata;
  assign BusReq    = r_bus_req;
  assign BusWe     = r_bus_we;
  assign BusAddr   = r_bus_addr;
  assign BusWData  = r_bus_wdata;
  assign BusBE     = r_bus_be;

endmodule

// File: tb/tb_lsu_bus_sequencer.sv
// Bench for lsu_bus_sequencer: directed scenarios plus randomized loads/stores
// against a byte-level memory model and a randomized-latency bus responder.
// All stimulus and responder actions run in one process, one step per clock.
module tb_lsu_bus_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemReadM, MemWriteM;
  logic [2:0]  StrobeM;
  logic [31:0] AddrM, WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        BusReq, BusWe;
  logic [31:0] BusAddr, BusWData;
  logic [3:0]  BusBE;
  logic [31:0] BusRData;
  logic        BusAck;

  lsu_bus_sequencer #(.ADDR_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .StrobeM(StrobeM), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadDataM(ReadDataM), .BusReq(BusReq), .BusWe(BusWe),
    .BusAddr(BusAddr), .BusWData(BusWData), .BusBE(BusBE),
    .BusRData(BusRData), .BusAck(BusAck)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Bus-side memory (written by DUT transactions) and reference memory (written by the model)
  logic [7:0]  bmem [0:1023];
  logic [7:0]  rmem [0:1023];

  // Responder state and transaction log
  int          ack_total = 0;
  int          base_ack  = 0;
  int          dly0 = 0, dly1 = 0;
  int          rsp_cnt = 0;
  logic        inject_ack = 1'b0;
  logic [31:0] rec_addr [16];
  logic [31:0] rec_wd   [16];
  logic [3:0]  rec_be   [16];
  logic        rec_we   [16];
  logic [31:0] exp_rdata = 32'h0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      bmem[(a[9:0] + 10'(i))] = v[8*i +: 8];
      rmem[(a[9:0] + 10'(i))] = v[8*i +: 8];
    end
  endtask

  // Bus responder for one cycle: acks after a per-transaction wait count
  task automatic bus_respond();
    int d;
    logic [7:0] wi;
    BusAck   = 1'b0;
    BusRData = $urandom;
    if (inject_ack) begin
      BusAck = 1'b1;
    end else if (RST) begin
      rsp_cnt = 0;
    end else if (BusReq) begin
      d = (ack_total == base_ack) ? dly0 : dly1;
      if (rsp_cnt >= d) begin
        wi = BusAddr[9:2];
        BusAck   = 1'b1;
        BusRData = {bmem[{wi, 2'd3}], bmem[{wi, 2'd2}], bmem[{wi, 2'd1}], bmem[{wi, 2'd0}]};
        if (BusWe) begin
          for (int l = 0; l < 4; l++)
            if (BusBE[l]) bmem[{wi, 2'(l)}] = BusWData[8*l +: 8];
        end
        rec_addr[ack_total % 16] = BusAddr;
        rec_wd[ack_total % 16]   = BusWData;
        rec_be[ack_total % 16]   = BusBE;
        rec_we[ack_total % 16]   = BusWe;
        ack_total++;
        rsp_cnt = 0;
      end else begin
        rsp_cnt++;
      end
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    bus_respond();
  endtask

  // One memory instruction: model expectations, drive, wait for stall release, compare
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] strb,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int d0, input int d1, output int stall);
    int          n, nt, t, estall, ntx, idx;
    logic [31:0] w0, a, val;
    logic [63:0] wd64, m;
    logic [3:0]  ebe [2];
    n    = (strb[1:0] == 2'b00) ? 1 : (strb[1:0] == 2'b01) ? 2 : 4;
    w0   = {addr[31:2], 2'b00};
    wd64 = {32'b0, wdata} << (8 * addr[1:0]);
    ebe[0] = 4'b0; ebe[1] = 4'b0; nt = 1; val = 32'b0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      t = (a[31:2] != addr[31:2]) ? 1 : 0;
      if (t == 1) nt = 2;
      ebe[t][a[1:0]] = 1'b1;
      if (wr) rmem[a[9:0]] = wdata[8*k +: 8];
      val[8*k +: 8] = rmem[a[9:0]];
    end
    if (rd && !wr) begin
      m = (64'd1 << (8 * n)) - 64'd1;
      if (!strb[2] && val[8*n-1]) val = val | ~m[31:0];
      exp_rdata = val;
    end
    estall = 1 + (d0 + 1) + ((nt == 2) ? (d1 + 1) : 0);

    @(posedge CLK); #1;
    MemReadM = rd; MemWriteM = wr; StrobeM = strb; AddrM = addr; WriteDataM = wdata;
    base_ack = ack_total; dly0 = d0; dly1 = d1;
    stall = 0;
    for (int c = 0; c < 64; c++) begin
      cyc();
      if (!StallM) break;
      stall++;
    end
    ntx = ack_total - base_ack;
    check_val("stall_cycles", stall, estall);
    check_val("txn_count", ntx, nt);
    for (int t2 = 0; t2 < nt; t2++) begin
      if (t2 < ntx) begin
        idx = (base_ack + t2) % 16;
        check_val("txn_addr", rec_addr[idx], w0 + 32'(4 * t2));
        check_val("txn_be", {28'b0, rec_be[idx]}, {28'b0, ebe[t2]});
        check_val("txn_wdata", rec_wd[idx], (t2 == 0) ? wd64[31:0] : wd64[63:32]);
        check_val("txn_we", {31'b0, rec_we[idx]}, {31'b0, wr});
      end
    end
    check_val("done_rdata", ReadDataM, exp_rdata);
    check_val("done_busreq", {31'b0, BusReq}, 32'd0);
    check_val("done_busbe", {28'b0, BusBE}, 32'd0);
  endtask

  initial begin
    int          st, got, k;
    logic [2:0]  rs;
    logic        rd, wr;
    RST = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; StrobeM = 3'b0;
    AddrM = 32'h0; WriteDataM = 32'h0; BusAck = 1'b0; BusRData = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      bmem[i] = 8'($urandom);
      rmem[i] = bmem[i];
    end
    #1;
    check_val("rst_stall", {31'b0, StallM}, 32'd0);
    check_val("rst_busreq", {31'b0, BusReq}, 32'd0);
    check_val("rst_buswe", {31'b0, BusWe}, 32'd0);
    check_val("rst_busaddr", BusAddr, 32'd0);
    check_val("rst_buswdata", BusWData, 32'd0);
    check_val("rst_busbe", {28'b0, BusBE}, 32'd0);
    check_val("rst_rdata", ReadDataM, 32'd0);
    MemReadM = 1'b1; #1;
    check_val("rst_masks_stall", {31'b0, StallM}, 32'd0);
    MemReadM = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Aligned LW, ack in the first FIRST cycle
    set_word(32'h100, 32'hDEADBEEF);
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, st);
    check_val("lw_stall2", st, 2);
    check_val("lw_rdata", ReadDataM, 32'hDEADBEEF);

    // LB / LBU in the top lane
    set_word(32'h200, 32'h80123456);
    run_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 0, st);
    check_val("lb_rdata", ReadDataM, 32'hFFFFFF80);
    check_val("lb_be", {28'b0, rec_be[(ack_total - 1) % 16]}, 32'h8);
    run_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 1, 0, st);
    check_val("lbu_rdata", ReadDataM, 32'h00000080);

    // Split SH across a word boundary
    run_access(1'b0, 1'b1, 3'b001, 32'h103, 32'h0000ABCD, 0, 0, st);
    check_val("sh_addr0", rec_addr[(ack_total - 2) % 16], 32'h100);
    check_val("sh_be0", {28'b0, rec_be[(ack_total - 2) % 16]}, 32'h8);
    check_val("sh_wd0", rec_wd[(ack_total - 2) % 16], 32'hCD000000);
    check_val("sh_addr1", rec_addr[(ack_total - 1) % 16], 32'h104);
    check_val("sh_be1", {28'b0, rec_be[(ack_total - 1) % 16]}, 32'h1);
    check_val("sh_wd1", rec_wd[(ack_total - 1) % 16], 32'h000000AB);
    check_val("sh_stall3", st, 3);

    // Split LW with two wait cycles per transaction
    set_word(32'h100, 32'h11223344);
    set_word(32'h104, 32'h55667788);
    run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 2, 2, st);
    check_val("lw_split_rdata", ReadDataM, 32'h77881122);
    check_val("lw_split_stall", st, 7);

    // Reset during SECOND while the ack is outstanding
    @(posedge CLK); #1;
    MemReadM = 1'b1; MemWriteM = 1'b0; StrobeM = 3'b010; AddrM = 32'h302;
    base_ack = ack_total; dly0 = 0; dly1 = 20;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (ack_total != base_ack) begin got = 1; break; end
    end
    check_val("rst_test_first_ack", got, 1);
    @(posedge CLK); #1;
    check_val("rst_test_req_second", {31'b0, BusReq}, 32'd1);
    check_val("rst_test_addr_second", BusAddr, 32'h304);
    #1 RST = 1'b1;
    #1;
    check_val("rst_mid_busreq", {31'b0, BusReq}, 32'd0);
    check_val("rst_mid_stall", {31'b0, StallM}, 32'd0);
    check_val("rst_mid_rdata", ReadDataM, 32'd0);
    exp_rdata = 32'h0;
    cyc();
    @(posedge CLK); #1;
    MemReadM = 1'b0; RST = 1'b0; inject_ack = 1'b1;
    cyc();
    inject_ack = 1'b0;
    cyc();
    check_val("late_ack_stall", {31'b0, StallM}, 32'd0);
    check_val("late_ack_busreq", {31'b0, BusReq}, 32'd0);
    check_val("late_ack_busbe", {28'b0, BusBE}, 32'd0);
    check_val("late_ack_rdata", ReadDataM, 32'd0);
    run_access(1'b0, 1'b1, 3'b010, 32'h0, 32'h12345678, 0, 0, st);
    check_val("sw0_be", {28'b0, rec_be[(ack_total - 1) % 16]}, 32'hF);
    check_val("sw0_wd", rec_wd[(ack_total - 1) % 16], 32'h12345678);

    // Back-to-back SW then LW to the same address
    run_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 1, 0, st);
    run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, 0, st);
    check_val("b2b_rdata", ReadDataM, 32'hCAFEF00D);
    check_val("b2b_stall", st, 2);

    // Randomized mix of loads, stores and idle cycles
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      if (k == 9) begin
        @(posedge CLK); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        cyc();
        check_val("idle_stall", {31'b0, StallM}, 32'd0);
        check_val("idle_busreq", {31'b0, BusReq}, 32'd0);
        check_val("idle_rdata_hold", ReadDataM, exp_rdata);
      end else begin
        rd = (k < 4) || (k == 8);
        wr = (k >= 4);
        rs = 3'($urandom);
        run_access(rd, wr, rs, 32'($urandom_range(0, 1023)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), st);
      end
    end

    @(posedge CLK); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_sequencer.md
# lsu_bus_sequencer

Memory-stage load/store sequencer for the pipelined RV32I core. It takes the decoded memory request (load/store, funct3 strobe, byte address, store data) and runs it on a word-wide request/acknowledge data bus. It splits misaligned halfword/word accesses into two aligned bus transactions and stalls the pipeline until the access completes. It also returns the aligned, sign- or zero-extended load result.

## Interface
- ADDR_WIDTH, 32, byte-address width of AddrM and BusAddr
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- MemReadM  in  1  load in memory stage
- MemWriteM  in  1  store in memory stage; wins if both high
- StrobeM  in  3  funct3: [1:0] size (00 byte, 01 half, 1x word), [2] unsigned load
- AddrM  in  ADDR_WIDTH  byte address
- WriteDataM  in  32  store data, right-justified
- StallM  out  1  hold fetch/decode/execute/memory stages
- ReadDataM  out  32  extended load result, registered
- BusReq  out  1  transaction request
- BusWe  out  1  1 = write
- BusAddr  out  ADDR_WIDTH  word-aligned address ([1:0] = 00)
- BusWData  out  32  lane-positioned write data
- BusBE  out  4  byte enables, bit i = byte lane i
- BusRData  in  32  read data, valid with BusAck
- BusAck  in  1  one-cycle completion pulse

## Operation
- States: IDLE, FIRST, SECOND, DONE.
- Inputs are held stable by the pipeline while StallM = 1.
- IDLE:
  - on MemReadM|MemWriteM, register bus outputs for the first transaction and go to FIRST;
  - otherwise stay.
- FIRST: BusReq = 1. On BusAck:
  - split access: go to SECOND;
  - otherwise: DONE.
- SECOND: BusReq = 1, address + 4. On BusAck go to DONE.
- DONE: go to IDLE unconditionally, one cycle.
- StallM = (IDLE & (MemReadM|MemWriteM)) | FIRST | SECOND. StallM = 0 in DONE, and is forced 0 while RST is high.
- Lane math, with off = AddrM[1:0] and n = 1, 2 or 4 bytes:
  - mask8 = ((1<<n)-1) << off;
  - split = off + n > 4, i.e. half at off 3, word at off 1/2/3.
- First transaction: BusAddr = {AddrM[hi:2],00}, BusBE = mask8[3:0], BusWData = (WriteDataM << 8*off)[31:0].
- Second transaction: BusAddr + 4, BusBE = mask8[7:4], BusWData = ({32'b0,WriteDataM} << 8*off)[63:32].
- Loads:
  - capture BusRData of the first ack into lo;
  - capture the second into hi, which is 0 when not split;
  - raw = ({hi,lo} >> 8*off)[31:0];
  - take the low n bytes, then sign-extend from the top byte when StrobeM[2] = 0, else zero-extend.
- ReadDataM updates only at the final ack of a load. It holds otherwise, including through stores.
- StrobeM[1:0] = 11 is treated as word.
- BusReq, BusWe, BusAddr, BusWData and BusBE stay stable from assertion until the ack cycle. They are cleared to 0 the cycle after the final ack.
- Outside FIRST/SECOND: BusReq = 0 and BusBE = 0.

## Timing
- Reset values: state IDLE; StallM, BusReq, BusWe, BusAddr, BusWData, BusBE, ReadDataM all 0; lo/hi 0.
- RST asserted in any state (including mid-transaction with BusReq high): BusReq drops immediately (asynchronous) and any pending ack is ignored.
- Aligned access, ack in first FIRST cycle:
  - cycle 0: IDLE, StallM = 1;
  - cycle 1: FIRST with ack, StallM = 1;
  - cycle 2: DONE, StallM = 0, ReadDataM valid.
  - StallM is high 2 cycles, plus 1 per wait cycle.
- Split access: minimum StallM high 3 cycles.
- BusAck seen in IDLE or DONE is ignored.
- Back-to-back memory instructions: the next one reaches the memory stage in the cycle after DONE and is accepted in IDLE. No request is lost and no idle bubble beyond DONE is added.

## Test plan
- LW 0x100, memory 0xDEADBEEF, BusAck in first FIRST cycle -> BusAddr 0x100, BusBE 1111, BusWe 0; StallM high exactly 2 cycles; ReadDataM = 0xDEADBEEF in DONE.
- LB then LBU at 0x203, BusRData 0x80123456 -> BusBE 1000; ReadDataM 0xFFFFFF80 then 0x00000080.
- SH 0x103, WriteDataM 0x0000ABCD -> first txn 0x100 / BE 1000 / WData 0xCD000000; second txn 0x104 / BE 0001 / WData 0x000000AB; BusWe 1 for both.
- LW 0x102, words 0x11223344 at 0x100 and 0x55667788 at 0x104, BusAck delayed 2 cycles each -> ReadDataM 0x77881122; StallM high 7 cycles.
- RST pulsed during SECOND while waiting for ack -> BusReq and StallM 0 immediately, ReadDataM 0. A late BusAck is ignored. After release, SW 0x0 of 0x12345678 completes with BE 1111.
- SW 0x10 immediately followed by LW 0x10 -> two distinct bus transactions, second accepted the cycle after DONE; load returns the stored value from the bus model.
